// File: rtl/fifo_deq_serializer.sv
// ---------------------------------------------------------------------------
// fifo_deq_serializer
//
// Read-side neighbour of the async FIFO. Takes full-width words from the FIFO
// deq handshake and emits each one as RATIO narrower beats on a ready/valid
// link, least-significant slice first. out_last marks the final beat of a
// word. A single word buffer is enough: the next word is accepted in the
// same cycle that the final beat of the current word is taken, so the block
// runs without bubbles.
//
// Parameters:
//   WIDTH      input word width (must match the FIFO WIDTH)
//   OUT_WIDTH  output beat width (WIDTH must be an integer multiple)
//
// Ports:
//   clock      sole clock (FIFO deq clock)
//   reset      synchronous, active-high reset
//   in_ready   word accept, drives FIFO deq_ready
//   in_valid   word available, from FIFO deq_valid
//   in_bits    word, from FIFO deq_bits
//   out_ready  downstream accepts the current beat
//   out_valid  beat available
//   out_bits   current beat
//   out_last   high on the final beat of a word
// ---------------------------------------------------------------------------
module fifo_deq_serializer #(
    parameter int WIDTH     = 64,
    parameter int OUT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    output logic                 in_ready,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_bits,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [OUT_WIDTH-1:0] out_bits,
    output logic                 out_last
);

    localparam int unsigned RATIO = WIDTH / OUT_WIDTH;
    localparam int unsigned CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] buf_q;
    logic [CNT_W-1:0] cnt_q;

    logic in_fire;
    logic out_fire;

    // out_valid / out_last come straight from flops (state, cnt_q); only
    // in_ready depends combinationally on an input (out_ready, reset).
    assign out_valid = (state == SEND);
    assign out_last  = (state == SEND) && (cnt_q == LAST_CNT);
    assign out_fire  = out_valid && out_ready;
    assign in_ready  = !reset && ((state == IDLE) || (out_fire && out_last));
    assign in_fire   = in_valid && in_ready;

    // Beat select from the held word only; in_bits never reaches out_bits
    // combinationally.
    always_comb begin
        out_bits = '0;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                out_bits = buf_q[i*OUT_WIDTH +: OUT_WIDTH];
            end
        end
    end

    // buf_q is deliberately left out of reset: it is only observable while
    // state == SEND, which always follows a load.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_fire) begin
                        buf_q <= in_bits;
                        cnt_q <= '0;
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (out_fire) begin
                        if (!out_last) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end else begin
                            cnt_q <= '0;
                            if (in_fire) begin
                                buf_q <= in_bits;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_deq_serializer.sv
module tb_fifo_deq_serializer;

    logic        clock;
    logic        reset;

    // DUT A: 64 -> 16 (RATIO 4)
    logic        in_ready_a, in_valid_a, out_ready_a, out_valid_a, out_last_a;
    logic [63:0] in_bits_a;
    logic [15:0] out_bits_a;

    // DUT B: 64 -> 64 (RATIO 1)
    logic        in_ready_b, in_valid_b, out_ready_b, out_valid_b, out_last_b;
    logic [63:0] in_bits_b;
    logic [63:0] out_bits_b;

    int checks   = 0;
    int failures = 0;

    fifo_deq_serializer #(.WIDTH(64), .OUT_WIDTH(16)) dut_a (
        .clock    (clock),
        .reset    (reset),
        .in_ready (in_ready_a),
        .in_valid (in_valid_a),
        .in_bits  (in_bits_a),
        .out_ready(out_ready_a),
        .out_valid(out_valid_a),
        .out_bits (out_bits_a),
        .out_last (out_last_a)
    );

    fifo_deq_serializer #(.WIDTH(64), .OUT_WIDTH(64)) dut_b (
        .clock    (clock),
        .reset    (reset),
        .in_ready (in_ready_b),
        .in_valid (in_valid_b),
        .in_bits  (in_bits_b),
        .out_ready(out_ready_b),
        .out_valid(out_valid_b),
        .out_bits (out_bits_b),
        .out_last (out_last_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        in_valid;
        logic [63:0] in_bits;
        logic        out_ready;
        logic        exp_in_ready;
        logic        exp_out_valid;
        logic [15:0] exp_bits;
        logic        exp_last;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic iv, input logic [63:0] ib, input logic ordy,
                       input logic eir, input logic eov, input logic [15:0] eb,
                       input logic el);
        vec_t v;
        v.in_valid = iv; v.in_bits = ib; v.out_ready = ordy;
        v.exp_in_ready = eir; v.exp_out_valid = eov; v.exp_bits = eb; v.exp_last = el;
        tbl.push_back(v);
    endtask

    // Randomised run against a queue model: the queue holds the beats of the
    // word currently held, the head being the beat on the output.
    task automatic run_random(input int dut, input int nwords, input bit full);
        int          ow;
        int          ratio;
        int          sent;
        int          cycles;
        logic [63:0] q[$];
        logic [63:0] mask;
        logic        iv, ordy, exp_ir;
        logic [63:0] ib;
        logic        a_ir, a_ov, a_last;
        logic [63:0] a_bits;
        ow     = (dut == 0) ? 16 : 64;
        ratio  = 64 / ow;
        mask   = (ow == 64) ? '1 : ((64'd1 << ow) - 64'd1);
        sent   = 0;
        cycles = 0;
        while ((sent < nwords || q.size() != 0) && cycles < 4000) begin
            @(negedge clock);
            cycles++;
            iv   = (sent < nwords) && (full || ($urandom_range(0, 3) != 0));
            ib   = {$urandom(), $urandom()};
            ordy = full || ($urandom_range(0, 3) != 0);
            if (dut == 0) begin
                in_valid_a = iv; in_bits_a = ib; out_ready_a = ordy;
            end else begin
                in_valid_b = iv; in_bits_b = ib; out_ready_b = ordy;
            end
            #1;
            if (dut == 0) begin
                a_ir = in_ready_a; a_ov = out_valid_a; a_bits = 64'(out_bits_a); a_last = out_last_a;
            end else begin
                a_ir = in_ready_b; a_ov = out_valid_b; a_bits = out_bits_b; a_last = out_last_b;
            end
            exp_ir = (q.size() == 0) || (ordy && q.size() == 1);
            chk("rnd_in_ready", 64'(a_ir), 64'(exp_ir));
            chk("rnd_out_valid", 64'(a_ov), 64'(q.size() != 0));
            if (q.size() != 0) begin
                chk("rnd_out_bits", a_bits, q[0]);
                chk("rnd_out_last", 64'(a_last), 64'(q.size() == 1));
            end
            if (q.size() != 0 && ordy) void'(q.pop_front());
            if (iv && exp_ir) begin
                for (int r = 0; r < ratio; r++) q.push_back((ib >> (r * ow)) & mask);
                sent++;
            end
        end
        if (cycles >= 4000) chk("rnd_timeout", 64'd0, 64'd1);
        @(negedge clock);
        in_valid_a = 1'b0; in_valid_b = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        in_valid_a = 1'b1; in_bits_a = 64'h0; out_ready_a = 1'b1;
        in_valid_b = 1'b1; in_bits_b = 64'h0; out_ready_b = 1'b1;

        // Reset held 3 cycles with in_valid high
        @(posedge clock);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("rst_in_ready_a", 64'(in_ready_a), 64'd0);
            chk("rst_out_valid_a", 64'(out_valid_a), 64'd0);
            chk("rst_in_ready_b", 64'(in_ready_b), 64'd0);
            chk("rst_out_valid_b", 64'(out_valid_b), 64'd0);
        end
        @(negedge clock);
        reset = 1'b0; in_valid_a = 1'b0; in_valid_b = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("idle_in_ready", 64'(in_ready_a), 64'd1);
            chk("idle_out_valid", 64'(out_valid_a), 64'd0);
            @(negedge clock);
        end

        // Single word
        add(1, 64'h4444_3333_2222_1111, 1, 1, 0, 16'h0, 0);
        add(0, 64'h0, 1, 0, 1, 16'h1111, 0);
        add(0, 64'h0, 1, 0, 1, 16'h2222, 0);
        add(0, 64'h0, 1, 0, 1, 16'h3333, 0);
        add(0, 64'h0, 1, 1, 1, 16'h4444, 1);
        add(0, 64'h0, 1, 1, 0, 16'h0, 0);
        // Back-to-back words A, B
        add(1, 64'hA003_A002_A001_A000, 1, 1, 0, 16'h0, 0);
        add(1, 64'hB003_B002_B001_B000, 1, 0, 1, 16'hA000, 0);
        add(1, 64'hB003_B002_B001_B000, 1, 0, 1, 16'hA001, 0);
        add(1, 64'hB003_B002_B001_B000, 1, 0, 1, 16'hA002, 0);
        add(1, 64'hB003_B002_B001_B000, 1, 1, 1, 16'hA003, 1);
        add(0, 64'h0, 1, 0, 1, 16'hB000, 0);
        add(0, 64'h0, 1, 0, 1, 16'hB001, 0);
        add(0, 64'h0, 1, 0, 1, 16'hB002, 0);
        add(0, 64'h0, 1, 1, 1, 16'hB003, 1);
        add(0, 64'h0, 1, 1, 0, 16'h0, 0);
        // Backpressure on beat 2 for 5 cycles
        add(1, 64'h4444_3333_2222_1111, 1, 1, 0, 16'h0, 0);
        add(0, 64'h0, 1, 0, 1, 16'h1111, 0);
        add(0, 64'h0, 1, 0, 1, 16'h2222, 0);
        for (int i = 0; i < 5; i++) add(0, 64'h0, 0, 0, 1, 16'h3333, 0);
        add(0, 64'h0, 1, 0, 1, 16'h3333, 0);
        add(0, 64'h0, 1, 1, 1, 16'h4444, 1);
        add(0, 64'h0, 1, 1, 0, 16'h0, 0);

        foreach (tbl[i]) begin
            in_valid_a = tbl[i].in_valid;
            in_bits_a  = tbl[i].in_bits;
            out_ready_a = tbl[i].out_ready;
            #1;
            chk($sformatf("vec%0d_in_ready", i), 64'(in_ready_a), 64'(tbl[i].exp_in_ready));
            chk($sformatf("vec%0d_out_valid", i), 64'(out_valid_a), 64'(tbl[i].exp_out_valid));
            if (tbl[i].exp_out_valid) begin
                chk($sformatf("vec%0d_out_bits", i), 64'(out_bits_a), 64'(tbl[i].exp_bits));
                chk($sformatf("vec%0d_out_last", i), 64'(out_last_a), 64'(tbl[i].exp_last));
            end
            @(negedge clock);
        end
        in_valid_a = 1'b0;

        // Reset mid-word, then the next word starts at slice 0
        in_valid_a = 1'b1; in_bits_a = 64'hC3C3_C2C2_C1C1_C0C0; out_ready_a = 1'b1;
        @(negedge clock);
        in_valid_a = 1'b0;
        #1;
        chk("mid_beat0", 64'(out_bits_a), 64'h0000_0000_0000_C0C0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid_still", 64'(out_valid_a), 64'd1);
        chk("mid_rst_in_ready", 64'(in_ready_a), 64'd0);
        chk("mid_beat1", 64'(out_bits_a), 64'h0000_0000_0000_C1C1);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("mid_after_rst_valid", 64'(out_valid_a), 64'd0);
        chk("mid_after_rst_in_ready", 64'(in_ready_a), 64'd1);
        in_valid_a = 1'b1; in_bits_a = 64'hD3D3_D2D2_D1D1_D0D0;
        @(negedge clock);
        in_valid_a = 1'b0;
        #1;
        chk("mid_new_valid", 64'(out_valid_a), 64'd1);
        chk("mid_new_beat0", 64'(out_bits_a), 64'h0000_0000_0000_D0D0);
        chk("mid_new_last", 64'(out_last_a), 64'd0);
        for (int i = 0; i < 4; i++) @(negedge clock);
        #1;
        chk("mid_drained", 64'(out_valid_a), 64'd0);

        // Fresh reset before randomised runs so both models start empty
        @(negedge clock);
        reset = 1'b1; in_valid_a = 1'b0; in_valid_b = 1'b0;
        @(negedge clock);
        reset = 1'b0;

        run_random(0, 30, 1'b0);
        run_random(1, 10, 1'b0);
        run_random(1, 6, 1'b1);
        run_random(0, 4, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
